// File: rtl/input_buffer_writer.sv
// Acquisition-side frame writer for the analyser input buffer, with start pulse and done re-arm.
// Optional level-crossing capture trigger is enabled by defining CAPTURE_TRIGGER_EN.
module input_buffer_writer #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16,
  parameter int START_LEN  = 10,
  parameter int TRIG_LEVEL = 0
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic              arm_i,
  input  logic              continuous_i,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_valid_i,
  input  logic              done_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              start_o,
  output logic              busy_o,
  output logic              overrun_o,
  output logic [7:0]        frame_cnt_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR   = {ADDR_W{1'b1}};
  localparam logic [7:0]        START_LEN_C = 8'(START_LEN);

`ifdef CAPTURE_TRIGGER_EN
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FILL      = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    ARM       = 3'd4
  } state_t;
  localparam state_t ENTRY = ARM;
  localparam logic signed [DATA_W-1:0] TRIG_S = DATA_W'(TRIG_LEVEL);
`else
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    START     = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;
  localparam state_t ENTRY = FILL;
`endif

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   cnt_r, cnt_s;
  logic [7:0]          scnt_r, scnt_s;
  logic                wr_en_r, wr_en_s;
  logic [ADDR_W-1:0]   wr_addr_r, wr_addr_s;
  logic [DATA_W-1:0]   wr_data_r, wr_data_s;
  logic                start_r, start_s;
  logic                busy_r, busy_s;
  logic                overrun_r, overrun_s;
  logic [7:0]          frame_cnt_r, frame_cnt_s;
`ifdef CAPTURE_TRIGGER_EN
  logic signed [DATA_W-1:0] prev_r, prev_s;
  logic                     have_prev_r, have_prev_s;
`endif

  // Next-state and next-output logic for the capture sequencer.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    scnt_s      = scnt_r;
    wr_en_s     = 1'b0;
    wr_addr_s   = wr_addr_r;
    wr_data_s   = wr_data_r;
    start_s     = 1'b0;
    overrun_s   = overrun_r;
    frame_cnt_s = frame_cnt_r;
`ifdef CAPTURE_TRIGGER_EN
    prev_s      = prev_r;
    have_prev_s = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (arm_i) begin
          state_s   = ENTRY;
          cnt_s     = '0;
          overrun_s = 1'b0;
        end else begin
          state_s   = IDLE;
        end
      end
`ifdef CAPTURE_TRIGGER_EN
      ARM: begin
        have_prev_s = have_prev_r;
        if (sample_valid_i) begin
          // The crossing sample is the first sample of the frame.
          if (have_prev_r && (prev_r < TRIG_S) && ($signed(sample_i) >= TRIG_S)) begin
            wr_en_s   = 1'b1;
            wr_addr_s = '0;
            wr_data_s = sample_i;
            cnt_s     = ADDR_W'(1);
            state_s   = FILL;
          end else begin
            state_s   = ARM;
          end
          prev_s      = $signed(sample_i);
          have_prev_s = 1'b1;
        end else begin
          state_s = ARM;
        end
      end
`endif
      FILL: begin
        if (sample_valid_i) begin
          wr_en_s   = 1'b1;
          wr_addr_s = cnt_r;
          wr_data_s = sample_i;
          if (cnt_r == LAST_ADDR) begin
            cnt_s       = '0;
            scnt_s      = 8'd0;
            frame_cnt_s = frame_cnt_r + 8'd1;
            state_s     = START;
          end else begin
            cnt_s       = cnt_r + ADDR_W'(1);
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      START: begin
        if (sample_valid_i) begin
          overrun_s = 1'b1;
        end else begin
          overrun_s = overrun_r;
        end
        if (scnt_r < START_LEN_C) begin
          start_s = 1'b1;
          scnt_s  = scnt_r + 8'd1;
        end else begin
          scnt_s  = 8'd0;
          state_s = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (sample_valid_i) begin
          overrun_s = 1'b1;
        end else begin
          overrun_s = overrun_r;
        end
        if (done_i) begin
          state_s = continuous_i ? ENTRY : IDLE;
        end else begin
          state_s = WAIT_DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and registered-output update.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      scnt_r      <= 8'd0;
      wr_en_r     <= 1'b0;
      wr_addr_r   <= '0;
      wr_data_r   <= '0;
      start_r     <= 1'b0;
      busy_r      <= 1'b0;
      overrun_r   <= 1'b0;
      frame_cnt_r <= 8'd0;
`ifdef CAPTURE_TRIGGER_EN
      prev_r      <= '0;
      have_prev_r <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      scnt_r      <= scnt_s;
      wr_en_r     <= wr_en_s;
      wr_addr_r   <= wr_addr_s;
      wr_data_r   <= wr_data_s;
      start_r     <= start_s;
      busy_r      <= busy_s;
      overrun_r   <= overrun_s;
      frame_cnt_r <= frame_cnt_s;
`ifdef CAPTURE_TRIGGER_EN
      prev_r      <= prev_s;
      have_prev_r <= have_prev_s;
`endif
    end
  end

  assign wr_en_o     = wr_en_r;
  assign wr_addr_o   = wr_addr_r;
  assign wr_data_o   = wr_data_r;
  assign start_o     = start_r;
  assign busy_o      = busy_r;
  assign overrun_o   = overrun_r;
  assign frame_cnt_o = frame_cnt_r;

endmodule

// File: doc/input_buffer_writer.md
Name: input_buffer_writer

Overview:
Acquisition-side writer for the 1024-entry input sample buffer that the spectrum analyser reads through read_input_buffer_address_o/data_i.
- Takes a valid-qualified 16-bit sample stream and writes one full frame (addresses 0..DEPTH-1) into the buffer write port.
- After the frame is complete, it holds start_o high for START_LEN cycles to launch the analyser, then waits for the analyser's done before re-arming.
- Sits between the ADC/sample source and the buffer RAM / Spectrum_Analyser start_i.

Parameters:
ADDR_W, 10, buffer address width; DEPTH = 2**ADDR_W
DATA_W, 16, sample width
START_LEN, 10, cycles start_o is held high (1..255)
TRIG_LEVEL, 0, signed threshold used only with CAPTURE_TRIGGER_EN

Ports:
CLOCK_50  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
arm_i  in  1  level; begin a capture when sampled high in IDLE
continuous_i  in  1  level; re-arm automatically after done_i
sample_i  in  DATA_W  input sample (two's complement)
sample_valid_i  in  1  sample_i valid this cycle
done_i  in  1  analyser finished with buffer (one-cycle pulse)
wr_en_o  out  1  buffer write enable
wr_addr_o  out  ADDR_W  buffer write address
wr_data_o  out  DATA_W  buffer write data
start_o  out  1  analyser start (drives start_i)
busy_o  out  1  high in any state except IDLE
overrun_o  out  1  sticky; a valid sample was dropped while frame locked
frame_cnt_o  out  8  completed frames, wraps 255->0

Behaviour:
- Reset, asynchronous and checked at any time including mid-frame:
  - State = IDLE.
  - All outputs 0; write counter = 0; start counter = 0.
- All outputs are registered.
- States: IDLE, FILL, START, WAIT_DONE (plus ARM, see Optional Feature).
- IDLE:
  - wr_en_o=0. Samples are dropped and do not set overrun.
  - arm_i=1 -> FILL with counter=0.
- FILL, per sample_valid_i=1 at edge n:
  - At n+1: wr_en_o=1, wr_addr_o=counter, wr_data_o=sample_i; counter increments.
  - Cycles without valid give wr_en_o=0; wr_addr_o/wr_data_o hold their last values.
  - The valid that writes address DEPTH-1 moves the state to START and wraps the counter to 0.
  - frame_cnt_o increments in the same cycle.
  - arm_i is ignored once FILL has begun.
- START:
  - start_o=1 for exactly START_LEN consecutive cycles.
  - First cycle is the cycle after the last wr_en_o pulse, so the last write completes before start is seen.
  - Then -> WAIT_DONE.
- WAIT_DONE:
  - start_o=0.
  - done_i=1 -> FILL if continuous_i=1, else IDLE. The next frame's first sample goes to address 0.
- START and WAIT_DONE:
  - Any sample_valid_i=1 sets overrun_o. The sample is not written.
  - done_i in START is ignored, not latched.
- overrun_o clears only on reset or on the arm_i=1 transition out of IDLE.
- Same-cycle events:
  - done_i and sample_valid_i together in WAIT_DONE: the sample is dropped and overrun_o set; the state still advances.
- No handshake back-pressure to the source; the source is assumed free-running.

Optional Feature:
Macro CAPTURE_TRIGGER_EN.
- Defined:
  - arm_i moves IDLE -> ARM instead of FILL.
  - ARM registers the previous valid sample. It moves to FILL when prev < TRIG_LEVEL and current >= TRIG_LEVEL (signed compare).
  - The crossing sample itself is written to address 0.
  - continuous re-arm also passes through ARM.
  - Samples in ARM never set overrun_o.
- Undefined: no ARM state, no compare logic; arm_i goes directly to FILL.

Test Plan:
- Reset mid-frame: arm, feed 300 samples, assert rst_n=0 -> outputs 0 immediately. After release, re-arm + 1024 samples -> first write at addr 0.
- Single frame: arm_i=1, sample_valid_i=1 every cycle, data 0..1023 -> wr_addr_o=k with wr_data_o=k for k=0..1023; start_o high exactly 10 cycles after the last write; frame_cnt_o=1; busy_o=1 until done_i.
- Gapped input: valid every 3rd cycle, data 5,6,7... -> addresses contiguous 0..1023, no writes on idle cycles, start_o after address 1023 only.
- Overrun: continue valid samples during START/WAIT_DONE -> no wr_en_o, overrun_o=1; pulse done_i with continuous_i=0 -> IDLE, overrun_o stays 1 until next arm.
- Continuous: continuous_i=1, three done_i pulses -> three frames each starting at addr 0, frame_cnt_o=3; done_i pulsed during START -> ignored, start_o length unchanged.
- CAPTURE_TRIGGER_EN, TRIG_LEVEL=0: samples -5,-3,-1,2,4 -> first write addr 0 data 2; a sequence 3,5 with no upward crossing -> no writes.
